// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front-end.
package spi_slave_pkg;

  // Main frame sequencer states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  // Progress of the read-data response inside a READ_DATA frame
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_WAIT = 2'd1,
    RD_SEND = 2'd2,
    RD_DONE = 2'd3
  } rd_phase_e;

  // Command opcodes carried in the top two bits of each frame
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises MOSI frames into RAM command words and
// serialises the RAM read byte back onto MISO for read-data frames.
module spi_slave_ctrl
  import spi_slave_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   SS_n,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic [ADDR_SIZE+1:0]   rx_data,
  output logic                   rx_valid,
  input  logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_valid
);

  localparam int W     = ADDR_SIZE + 2;
  localparam int CNT_W = $clog2(W + 1);
  localparam int OUT_W = $clog2(DATA_W + 1);

  // Counter value of the final payload bit (bit 0 of the word)
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(ADDR_SIZE);
  localparam logic [OUT_W-1:0] OUT_FIRST = OUT_W'(DATA_W - 1);

  state_e           state_q, state_d;
  rd_phase_e        rd_phase_q, rd_phase_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0]     shift_in_q, shift_in_d;
  logic [W-1:0]     rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] shift_out_q, shift_out_d;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic             miso_q, miso_d;
  logic             rd_addr_seen_q, rd_addr_seen_d;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rd_phase_q     <= RD_NONE;
      bit_cnt_q      <= '0;
      shift_in_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      shift_out_q    <= '0;
      out_cnt_q      <= '0;
      miso_q         <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_phase_q     <= rd_phase_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_in_q     <= shift_in_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      shift_out_q    <= shift_out_d;
      out_cnt_q      <= out_cnt_d;
      miso_q         <= miso_d;
      rd_addr_seen_q <= rd_addr_seen_d;
    end
  end

  // Next-state, shift-in/shift-out and strobe generation
  always_comb begin
    state_d        = state_q;
    rd_phase_d     = rd_phase_q;
    bit_cnt_d      = bit_cnt_q;
    shift_in_d     = shift_in_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    shift_out_d    = shift_out_q;
    out_cnt_d      = out_cnt_q;
    miso_d         = miso_q;
    rd_addr_seen_d = rd_addr_seen_q;

    if (state_q != IDLE && SS_n) begin
      // Frame aborted: drop the partial word; a read already answered by
      // the RAM consumes the pending read address.
      state_d     = IDLE;
      rd_phase_d  = RD_NONE;
      bit_cnt_d   = '0;
      shift_in_d  = '0;
      shift_out_d = '0;
      out_cnt_d   = '0;
      miso_d      = 1'b0;
      if (rd_phase_q != RD_NONE) begin
        rd_addr_seen_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (!SS_n) begin
            state_d = CHK_CMD;
          end
        end

        CHK_CMD: begin
          // Selector bit decides write vs read; a second read frame in a
          // row is the read-data request.
          shift_in_d = {{(W-1){1'b0}}, MOSI};
          bit_cnt_d  = '0;
          if (!MOSI) begin
            state_d = WRITE;
          end else if (!rd_addr_seen_q) begin
            state_d = READ_ADD;
          end else begin
            state_d = READ_DATA;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          // Take payload bits until the word is complete, then ignore MOSI
          if (bit_cnt_q <= LAST_IDX) begin
            shift_in_d = {shift_in_q[W-2:0], MOSI};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_IDX) begin
              rx_data_d  = {shift_in_q[W-2:0], MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) begin
                rd_addr_seen_d = 1'b1;
              end
              if (state_q == READ_DATA) begin
                rd_phase_d = RD_WAIT;
              end
            end
          end

          if (state_q == READ_DATA) begin
            case (rd_phase_q)
              RD_WAIT: begin
                // First bit goes out on the same edge the byte is captured
                if (tx_valid) begin
                  miso_d      = tx_data[DATA_W-1];
                  shift_out_d = tx_data << 1;
                  out_cnt_d   = OUT_FIRST;
                  rd_phase_d  = RD_SEND;
                  if (DATA_W == 1) begin
                    rd_addr_seen_d = 1'b0;
                  end
                end
              end
              RD_SEND: begin
                if (out_cnt_q != '0) begin
                  miso_d      = shift_out_q[DATA_W-1];
                  shift_out_d = shift_out_q << 1;
                  out_cnt_d   = out_cnt_q - 1'b1;
                  if (out_cnt_q == OUT_W'(1)) begin
                    rd_addr_seen_d = 1'b0;
                  end
                end else begin
                  miso_d     = 1'b0;
                  rd_phase_d = RD_DONE;
                end
              end
              default: begin
                miso_d = 1'b0;
              end
            endcase
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl with scoreboard queues for command
// words and MISO bits.
module tb_spi_slave_ctrl;
  import spi_slave_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned rx_pulses = 0;
  logic [9:0] exp_rx_q[$];
  logic       exp_miso_q[$];

  spi_slave_ctrl #(.ADDR_SIZE(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, score any rx_valid strobe
  task automatic tick();
    logic [9:0] e;
    @(posedge clk);
    #1;
    if (rx_valid === 1'b1) begin
      rx_pulses++;
      chk("rx_expected", 32'(exp_rx_q.size() != 0), 32'd1);
      if (exp_rx_q.size() != 0) begin
        e = exp_rx_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e));
      end
    end
  endtask

  // Full 10-bit frame with SS_n held low afterwards
  task automatic send_frame(input logic [9:0] w);
    rx_pulses = 0;
    exp_rx_q.push_back(w);
    SS_n = 1'b0;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = w[i];
      tick();
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
  endtask

  initial begin
    logic [9:0] w;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    tick();
    tick();
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
    rst_n = 1'b1;
    tick();

    // Write-address frame
    send_frame({OP_WR_ADDR, 8'h35});
    chk("wa_valid_now", 32'(rx_valid), 32'd1);
    chk("wa_state", 32'(dut.state_q), 32'(WRITE));
    chk("wa_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
    MOSI = 1'b1;
    tick();
    chk("wa_valid_drop", 32'(rx_valid), 32'd0);
    chk("wa_data_stable", 32'(rx_data), 32'h035);
    tick();
    chk("wa_pulses", 32'(rx_pulses), 32'd1);
    end_frame();
    chk("wa_idle", 32'(dut.state_q), 32'(IDLE));

    // Write-data frame
    send_frame({OP_WR_DATA, 8'hAA});
    tick();
    tick();
    chk("wd_pulses", 32'(rx_pulses), 32'd1);
    chk("wd_pending", 32'(exp_rx_q.size()), 32'd0);
    end_frame();

    // Read-address frame
    send_frame({OP_RD_ADDR, 8'h35});
    chk("ra_state", 32'(dut.state_q), 32'(READ_ADD));
    chk("ra_rd_seen", 32'(dut.rd_addr_seen_q), 32'd1);
    end_frame();

    // Read-data frame, RAM answers one cycle after rx_valid
    send_frame({OP_RD_DATA, 8'h00});
    chk("rd_state", 32'(dut.state_q), 32'(READ_DATA));
    tick();
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    for (int i = 7; i >= 0; i--) exp_miso_q.push_back(tx_data[i]);
    for (int i = 0; i < 8; i++) begin
      tick();
      tx_valid = 1'b0;
      MOSI = ~MOSI;
      chk($sformatf("miso_bit%0d", 7 - i), 32'(MISO), 32'(exp_miso_q.pop_front()));
    end
    chk("rd_seen_clr", 32'(dut.rd_addr_seen_q), 32'd0);
    tick();
    chk("miso_after", 32'(MISO), 32'd0);
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("miso_stray_tx", 32'(MISO), 32'd0);
    chk("rd_pulses", 32'(rx_pulses), 32'd1);
    end_frame();

    // Selector-1 frame after a completed read goes back to READ_ADD
    send_frame({OP_RD_ADDR, 8'h12});
    chk("ra2_state", 32'(dut.state_q), 32'(READ_ADD));
    end_frame();

    // Abort after five bits
    rx_pulses = 0;
    SS_n = 1'b0;
    tick();
    w = 10'h3FF;
    for (int i = 9; i >= 5; i--) begin
      MOSI = w[i];
      tick();
    end
    end_frame();
    chk("ab_state", 32'(dut.state_q), 32'(IDLE));
    chk("ab_valid", 32'(rx_valid), 32'd0);
    chk("ab_rd_seen", 32'(dut.rd_addr_seen_q), 32'd1);
    tick();
    chk("ab_pulses", 32'(rx_pulses), 32'd0);
    send_frame({OP_WR_ADDR, 8'hF0});
    tick();
    chk("fresh_pulses", 32'(rx_pulses), 32'd1);
    end_frame();

    // SS_n rises on the edge that would take bit 0
    rx_pulses = 0;
    SS_n = 1'b0;
    tick();
    w = 10'h155;
    for (int i = 9; i >= 1; i--) begin
      MOSI = w[i];
      tick();
    end
    end_frame();
    tick();
    chk("late_ab_pulses", 32'(rx_pulses), 32'd0);
    chk("late_ab_state", 32'(dut.state_q), 32'(IDLE));

    // Reset at edge 6 of a read-data frame with a pending read address
    chk("pre_rst_seen", 32'(dut.rd_addr_seen_q), 32'd1);
    rx_pulses = 0;
    SS_n = 1'b0;
    tick();
    w = 10'h3C3;
    for (int i = 9; i >= 5; i--) begin
      MOSI = w[i];
      tick();
    end
    chk("pre_rst_state", 32'(dut.state_q), 32'(READ_DATA));
    rst_n = 1'b0;
    MOSI  = w[4];
    tick();
    chk("mr_state", 32'(dut.state_q), 32'(IDLE));
    chk("mr_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
    chk("mr_rx_data", 32'(rx_data), 32'd0);
    chk("mr_valid", 32'(rx_valid), 32'd0);
    chk("mr_miso", 32'(MISO), 32'd0);
    rst_n = 1'b1;
    SS_n = 1'b1;
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tick();
    tx_valid = 1'b0;
    chk("mr_stray_miso", 32'(MISO), 32'd0);
    chk("mr_pulses", 32'(rx_pulses), 32'd0);
    chk("final_pending", 32'(exp_rx_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- SPI slave front-end that sequences the team's single-port synchronous RAM.
- Deserialises 10-bit MOSI frames into RAM command words: 2-bit opcode plus 8-bit payload, opcodes 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- Issues each word with a one-cycle rx_valid.
- For read-data frames, waits for the RAM's tx_valid and serialises the returned byte onto MISO.
- Sits between the SPI pins and the RAM inside the SPI-slave top.

Parameters:
- ADDR_SIZE, 8, RAM address/payload width; command word width = ADDR_SIZE+2.
- DATA_W, 8, width of the read byte returned on tx_data and shifted on MISO.

Ports:
- clk  in  1  clock; SPI SCK domain, one MOSI bit per rising edge
- rst_n  in  1  reset, synchronous, active-low
- SS_n  in  1  slave select, active-low; high aborts the frame
- MOSI  in  1  serial in, MSB first
- MISO  out  1  serial out, MSB first
- rx_data  out  ADDR_SIZE+2  assembled command word to RAM
- rx_valid  out  1  one-cycle strobe, rx_data valid
- tx_data  in  DATA_W  read byte from RAM
- tx_valid  in  1  tx_data valid (RAM read response)

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. All outputs are registered.
- IDLE:
  - SS_n=0 → CHK_CMD.
  - Otherwise stay.
- CHK_CMD:
  - SS_n=1 → IDLE.
  - Otherwise sample MOSI as rx_data[MSB] (the frame selector bit).
  - MOSI=0 → WRITE.
  - MOSI=1 with rd_addr_seen=0 → READ_ADD.
  - MOSI=1 with rd_addr_seen=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA:
  - Shift in the remaining ADDR_SIZE+1 bits, one per edge while SS_n=0.
  - After the last bit, rx_valid=1 for exactly one cycle with rx_data stable.
  - Further MOSI bits are ignored until SS_n rises.
- Timing (edge 0 = SS_n sampled low in IDLE):
  - Selector bit at edge 1; bits 8..0 at edges 2..10.
  - rx_valid high in the cycle after edge 10.
- READ_ADD: rd_addr_seen set together with rx_valid.
- READ_DATA:
  - After rx_valid, wait for tx_valid.
  - On the edge tx_valid=1 is sampled, load tx_data into the shift register.
  - MISO then presents bit DATA_W-1 down to bit 0 over the next DATA_W cycles, then returns to 0.
  - rd_addr_seen clears when the last bit is driven.
  - With the synchronous RAM, MISO bit7..bit0 appear in cycles 13..20.
- tx_valid outside READ_DATA-wait is ignored. No timeout: the block waits for tx_valid until SS_n rises.
- SS_n=1 at any edge in a non-IDLE state:
  - Next state IDLE; partial word discarded, no rx_valid, MISO=0, counter cleared.
  - rd_addr_seen keeps its value, unless the abort falls after the READ_DATA rx_valid, in which case it clears.
- A bit sampled while SS_n=1 is never taken. SS_n rising on the edge that would take bit 0 → abort, no rx_valid.
- Opcode bits are forwarded unchecked; the RAM decodes them.
- rst_n low mid-frame wins over everything → reset values on that edge.

Decomposition:
- Package spi_slave_pkg holds:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA)
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11
- Single module; counter, shift-in and shift-out registers stay inline. No sub-module warranted.
- Top-level spi_wrapper instantiates this block and the RAM; it is outside this spec.

Test Plan:
- Write-address: SS_n low, MOSI 0_0_0011_0101 → rx_data=10'h035, rx_valid high for only the cycle after edge 10, state WRITE, rd_addr_seen=0.
- Write-data: new frame, MOSI 0_1_1010_1010 → rx_data=10'h1AA, single rx_valid pulse.
- Read-address then read-data:
  - Frame 1_0_0011_0101 → rx_data=10'h235, rd_addr_seen=1.
  - Next frame 1_1_0000_0000 → state READ_DATA, rx_data=10'h300.
  - RAM returns tx_data=8'hAA with tx_valid one cycle later → MISO 1,0,1,0,1,0,1,0 in cycles 13..20, then 0; rd_addr_seen=0.
  - A following selector-1 frame → READ_ADD.
- Abort: SS_n high after 5 bits → no rx_valid, IDLE next cycle. A fresh full frame 0_0_1111_0000 → rx_data=10'h0F0 correct.
- Reset mid-frame: rst_n=0 at edge 6 of a read-data frame with rd_addr_seen=1 → all outputs 0, rd_addr_seen=0, IDLE; a stray tx_valid afterwards leaves MISO=0.
